// File: rtl/s_inst_fetch.sv
// Scalar instruction fetch buffer: issues word-aligned fetches from an internal PC,
// queues returned instructions in order and hands them to the ALU; redirects flush it.
module s_inst_fetch #(
  parameter int DEPTH  = 4,
  parameter int PC_W   = 8,
  parameter int INST_W = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic                   imem_req_valid,
  output logic [PC_W-1:0]        imem_req_addr,
  input  logic                   imem_req_ready,
  input  logic                   imem_rsp_valid,
  input  logic [INST_W-1:0]      imem_rsp_data,
  input  logic                   set_pc,
  input  logic [PC_W-1:0]        pc_in,
  output logic                   inst_valid,
  output logic [INST_W-1:0]      inst_data,
  output logic [PC_W-1:0]        inst_pc,
  input  logic                   inst_ready,
  output logic [PC_W-1:0]        pc_out,
  output logic [$clog2(DEPTH):0] fifo_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] a);
    return a & ~PC_W'(3);
  endfunction

  function automatic logic [PC_W-1:0] next_pc(input logic [PC_W-1:0] a);
    return a + PC_W'(4);
  endfunction

  logic [PC_W-1:0]   fetch_pc;
  logic [PC_W-1:0]   rsp_pc;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     drop_cnt;
  logic [CW-1:0]     count;
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic [INST_W-1:0] data_mem [DEPTH];
  logic [PC_W-1:0]   pc_mem   [DEPTH];

  logic [CW:0] in_use;
  logic        accept;
  logic        push;
  logic        pop;

  // Credit covers both queued and in-flight words so a response can never overflow the FIFO.
  assign in_use         = {1'b0, outstanding} + {1'b0, count};
  assign imem_req_valid = (in_use < (CW+1)'(DEPTH)) && (drop_cnt == '0) && !set_pc && !reset;
  assign imem_req_addr  = fetch_pc;
  assign pc_out         = fetch_pc;
  assign accept         = imem_req_valid && imem_req_ready;
  assign push           = imem_rsp_valid && (drop_cnt == '0) && !set_pc;
  assign pop            = inst_valid && inst_ready;

  assign inst_valid = (count != '0);
  assign inst_data  = inst_valid ? data_mem[rd_ptr] : '0;
  assign inst_pc    = inst_valid ? pc_mem[rd_ptr]   : '0;
  assign fifo_count = count;

  // Fetch / credit / FIFO control stage
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc    <= '0;
      rsp_pc      <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else if (set_pc) begin
      fetch_pc    <= align_pc(pc_in);
      rsp_pc      <= align_pc(pc_in);
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      // Every request still in flight (already-pending drops included) is now stale.
      outstanding <= outstanding - CW'(imem_rsp_valid);
      drop_cnt    <= outstanding - CW'(imem_rsp_valid);
    end else begin
      if (accept)
        fetch_pc <= next_pc(fetch_pc);
      outstanding <= outstanding + CW'(accept) - CW'(imem_rsp_valid);
      if (imem_rsp_valid && (drop_cnt != '0))
        drop_cnt <= drop_cnt - CW'(1);
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        rsp_pc <= next_pc(rsp_pc);
      end
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // FIFO storage stage
  always_ff @(posedge clock) begin
    if (push) begin
      data_mem[wr_ptr] <= imem_rsp_data;
      pc_mem[wr_ptr]   <= rsp_pc;
    end
  end

endmodule
